// File: rtl/wb_trace_writer_if.sv
// Writeback-capture and trace-sink signal bundle for wb_trace_writer.
// master = datapath/sink side, slave = the trace writer itself.
interface wb_trace_writer_if;
    logic        trace_enable;
    logic        wb0_en;
    logic [4:0]  wb0_rd;
    logic [31:0] wb0_wdata;
    logic [31:0] wb0_pc;
    logic        wb1_en;
    logic [4:0]  wb1_rd;
    logic [31:0] wb1_wdata;
    logic [31:0] wb1_pc;
    logic        stall_req;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [4:0]  out_rd;
    logic [31:0] out_wdata;
    logic        out_order;
    logic        overflow;
    logic [7:0]  drop_cnt;

    modport master (
        output trace_enable, wb0_en, wb0_rd, wb0_wdata, wb0_pc,
               wb1_en, wb1_rd, wb1_wdata, wb1_pc, out_ready,
        input  stall_req, out_valid, out_pc, out_rd, out_wdata, out_order,
               overflow, drop_cnt
    );

    modport slave (
        input  trace_enable, wb0_en, wb0_rd, wb0_wdata, wb0_pc,
               wb1_en, wb1_rd, wb1_wdata, wb1_pc, out_ready,
        output stall_req, out_valid, out_pc, out_rd, out_wdata, out_order,
               overflow, drop_cnt
    );
endinterface

// File: rtl/wb_trace_writer.sv
// Dual-slot writeback capture into an FWFT record FIFO feeding a valid/ready trace sink.
// Optional macro TRACE_FILTER_EN drops records whose pc[31:3] matches FILTER_PC[31:3].
module wb_trace_writer #(
    parameter int          DEPTH     = 8,
    parameter logic [31:0] FILTER_PC = 32'hbfc00380
) (
    input logic              clock,
    input logic              reset,
    wb_trace_writer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C    = CW'(DEPTH);
    localparam logic [CW-1:0] NEAR_FULL  = CW'(DEPTH - 1);
`ifdef TRACE_FILTER_EN
    localparam bit FILTER_ON = 1'b1;
`else
    localparam bit FILTER_ON = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] wdata;
        logic        order;
    } rec_t;

    rec_t          r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;
    logic [7:0]    r_drop_cnt;

    rec_t          w_rec [2];
    rec_t          w_first;
    rec_t          w_out;
    logic [1:0]    w_q;
    logic [1:0]    w_n_req;
    logic [1:0]    w_n_push;
    logic [1:0]    w_n_drop;
    logic [CW-1:0] w_space;
    logic          w_pop;
    logic          w_valid;
    logic [8:0]    w_drop_sum;

    assign w_rec[0] = '{pc: bus.wb0_pc, rd: bus.wb0_rd, wdata: bus.wb0_wdata, order: 1'b0};
    assign w_rec[1] = '{pc: bus.wb1_pc, rd: bus.wb1_rd, wdata: bus.wb1_wdata, order: 1'b1};

    // FILTER_ON folds to a constant, so the compare vanishes when filtering is off.
    assign w_q[0] = bus.trace_enable & bus.wb0_en & (bus.wb0_rd != 5'd0)
                  & ~(FILTER_ON && (bus.wb0_pc[31:3] == FILTER_PC[31:3]));
    assign w_q[1] = bus.trace_enable & bus.wb1_en & (bus.wb1_rd != 5'd0)
                  & ~(FILTER_ON && (bus.wb1_pc[31:3] == FILTER_PC[31:3]));

    assign w_n_req = {1'b0, w_q[0]} + {1'b0, w_q[1]};
    assign w_space = DEPTH_C - r_count;

    // Space ignores a same-cycle pop; when short, the later (slot-1) record loses.
    always_comb begin
        w_n_push = w_n_req;
        if (w_space == CW'(0))
            w_n_push = 2'd0;
        else if (w_space == CW'(1) && w_n_req == 2'd2)
            w_n_push = 2'd1;
    end

    assign w_n_drop   = w_n_req - w_n_push;
    assign w_drop_sum = {1'b0, r_drop_cnt} + {7'd0, w_n_drop};
    assign w_first    = w_q[0] ? w_rec[0] : w_rec[1];
    assign w_valid    = (r_count != CW'(0));
    assign w_pop      = w_valid & bus.out_ready;

    always_ff @(posedge clock) begin
        if (w_n_push != 2'd0)
            r_mem[r_wr_ptr] <= w_first;
        if (w_n_push == 2'd2)
            r_mem[r_wr_ptr + AW'(1)] <= w_rec[1];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + AW'(w_n_push);
            r_rd_ptr <= r_rd_ptr + AW'(w_pop);
            r_count  <= r_count + CW'(w_n_push) - CW'(w_pop);
            if (w_n_drop != 2'd0) begin
                r_overflow <= 1'b1;
                r_drop_cnt <= w_drop_sum[8] ? 8'hff : w_drop_sum[7:0];
            end
        end
    end

    // Gate the head with valid so the outputs read zero while empty or in reset.
    assign w_out         = w_valid ? r_mem[r_rd_ptr] : '0;
    assign bus.out_valid = w_valid;
    assign bus.out_pc    = w_out.pc;
    assign bus.out_rd    = w_out.rd;
    assign bus.out_wdata = w_out.wdata;
    assign bus.out_order = w_out.order;
    assign bus.stall_req = (r_count >= NEAR_FULL);
    assign bus.overflow  = r_overflow;
    assign bus.drop_cnt  = r_drop_cnt;
endmodule

// File: tb/tb_wb_trace_writer.sv
// Bench for wb_trace_writer: directed scenarios plus random traffic against a queue model.
module tb_wb_trace_writer;
  localparam int          DEPTH     = 8;
  localparam logic [31:0] FILTER_PC = 32'hbfc00380;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] wdata;
    logic        order;
  } trec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_trace_writer_if bus();
  wb_trace_writer #(.DEPTH(DEPTH), .FILTER_PC(FILTER_PC)) dut (.clock(clk), .reset(rst), .bus(bus));

  trec_t mq[$];
  int    m_drops = 0;
  bit    m_ovf   = 0;
  int    n_cmp   = 0;
  int    n_bad   = 0;

  function automatic bit qual(logic en, logic [4:0] rd, logic [31:0] pc);
    bit filt = 0;
`ifdef TRACE_FILTER_EN
    filt = (pc[31:3] == FILTER_PC[31:3]);
`endif
    return bus.trace_enable && en && (rd != 0) && !filt;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_drops = 0;
    m_ovf   = 0;
  endtask

  // Queue semantics: space is measured before the pop, excess records are the later ones.
  task automatic model_edge();
    trec_t cand[$];
    trec_t t;
    bit    pop   = (mq.size() != 0) && bus.out_ready;
    int    space = DEPTH - mq.size();
    if (qual(bus.wb0_en, bus.wb0_rd, bus.wb0_pc)) cand.push_back('{bus.wb0_pc, bus.wb0_rd, bus.wb0_wdata, 1'b0});
    if (qual(bus.wb1_en, bus.wb1_rd, bus.wb1_pc)) cand.push_back('{bus.wb1_pc, bus.wb1_rd, bus.wb1_wdata, 1'b1});
    foreach (cand[i]) begin
      if (space > 0) begin
        mq.push_back(cand[i]);
        space--;
      end else begin
        m_ovf = 1;
        if (m_drops < 255) m_drops++;
      end
    end
    if (pop) t = mq.pop_front();
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  function automatic logic [80:0] exp_vec();
    trec_t h = '0;
    if (mq.size() != 0) h = mq[0];
    return {mq.size() != 0, h.pc, h.rd, h.wdata, h.order, mq.size() >= DEPTH - 1, m_ovf, 8'(m_drops)};
  endfunction

  function automatic logic [80:0] obs_vec();
    return {bus.out_valid, bus.out_pc, bus.out_rd, bus.out_wdata, bus.out_order,
            bus.stall_req, bus.overflow, bus.drop_cnt};
  endfunction

  function automatic trec_t head();
    return '{bus.out_pc, bus.out_rd, bus.out_wdata, bus.out_order};
  endfunction

  task automatic idle();
    bus.wb0_en = 0; bus.wb0_rd = 0; bus.wb0_wdata = 0; bus.wb0_pc = 0;
    bus.wb1_en = 0; bus.wb1_rd = 0; bus.wb1_wdata = 0; bus.wb1_pc = 0;
  endtask

  task automatic drive(input int s, input trec_t r);
    if (s == 0) begin
      bus.wb0_en = 1; bus.wb0_rd = r.rd; bus.wb0_wdata = r.wdata; bus.wb0_pc = r.pc;
    end else begin
      bus.wb1_en = 1; bus.wb1_rd = r.rd; bus.wb1_wdata = r.wdata; bus.wb1_pc = r.pc;
    end
  endtask

  function automatic trec_t mkrec(int k, bit ord);
    trec_t r;
    r.pc    = 32'h8000_1000 + 32'(k) * 4;
    r.rd    = 5'((k % 31) + 1);
    r.wdata = $urandom;
    r.order = ord;
    return r;
  endfunction

  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if (obs_vec() !== 81'b0) begin
      n_bad++; $display("FAIL reset_state: got %h want %h", obs_vec(), 81'b0);
    end
    rst = 0;
    tick();
    n_cmp++;
    if (obs_vec() !== exp_vec()) begin
      n_bad++; $display("FAIL reset_idle: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_dual();
    bus.out_ready = 1;
    drive(0, '{32'hbfc00000, 5'd2, 32'h11, 1'b0});
    drive(1, '{32'hbfc00004, 5'd3, 32'h22, 1'b1});
    tick();
    idle();
    n_cmp++;
    if (head() !== trec_t'({32'hbfc00000, 5'd2, 32'h11, 1'b0}) || bus.out_valid !== 1'b1) begin
      n_bad++; $display("FAIL dual_beat0: got v=%b %h want v=1 %h", bus.out_valid, head(),
                        trec_t'({32'hbfc00000, 5'd2, 32'h11, 1'b0}));
    end
    tick();
    n_cmp++;
    if (head() !== trec_t'({32'hbfc00004, 5'd3, 32'h22, 1'b1}) || bus.out_valid !== 1'b1) begin
      n_bad++; $display("FAIL dual_beat1: got v=%b %h want v=1 %h", bus.out_valid, head(),
                        trec_t'({32'hbfc00004, 5'd3, 32'h22, 1'b1}));
    end
    tick();
    n_cmp++;
    if (obs_vec() !== exp_vec() || bus.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL dual_empty: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_single_slot();
    trec_t r = '{32'hbfc00010, 5'd5, $urandom, 1'b1};
    drive(1, r);
    tick();
    idle();
    n_cmp++;
    if (head() !== r || bus.out_valid !== 1'b1) begin
      n_bad++; $display("FAIL slot1_alone: got v=%b %h want v=1 %h", bus.out_valid, head(), r);
    end
    tick();
    drive(0, '{32'hbfc00020, 5'd0, 32'hdead, 1'b0});
    tick();
    idle();
    n_cmp++;
    if (bus.out_valid !== 1'b0 || obs_vec() !== exp_vec()) begin
      n_bad++; $display("FAIL rd0_dropped: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_overflow();
    trec_t sent[$];
    bus.out_ready = 0;
    for (int c = 0; c < 6; c++) begin
      trec_t a = mkrec(2 * c, 1'b0);
      trec_t b = mkrec(2 * c + 1, 1'b1);
      sent.push_back(a); sent.push_back(b);
      drive(0, a); drive(1, b);
      tick();
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL ovf_fill c=%0d: got %h want %h", c, obs_vec(), exp_vec());
      end
      n_cmp++;
      if (bus.stall_req !== (c >= 3)) begin
        n_bad++; $display("FAIL ovf_stall c=%0d: got %b want %b", c, bus.stall_req, c >= 3);
      end
    end
    idle();
    n_cmp++;
    if (bus.overflow !== 1'b1 || bus.drop_cnt !== 8'd4) begin
      n_bad++; $display("FAIL ovf_drops: got ovf=%b cnt=%0d want ovf=1 cnt=4", bus.overflow, bus.drop_cnt);
    end
    bus.out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (head() !== sent[i] || bus.out_valid !== 1'b1) begin
        n_bad++; $display("FAIL ovf_drain i=%0d: got v=%b %h want %h", i, bus.out_valid, head(), sent[i]);
      end
      tick();
    end
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL ovf_drained: got v=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_wrap();
    trec_t sent[$];
    int    nx = 0;
    int    k  = 100;
    bus.out_ready = 0;
    for (int i = 0; i < 7; i++) begin
      trec_t r = mkrec(k++, 1'b0);
      sent.push_back(r); drive(0, r);
      tick();
    end
    bus.out_ready = 1;
    for (int i = 0; i < 20; i++) begin
      trec_t r = mkrec(k++, 1'b0);
      sent.push_back(r); drive(0, r);
      n_cmp++;
      if (head() !== sent[nx] || bus.stall_req !== 1'b1 || bus.drop_cnt !== 8'd4) begin
        n_bad++; $display("FAIL wrap i=%0d: got %h stall=%b cnt=%0d want %h stall=1 cnt=4",
                          i, head(), bus.stall_req, bus.drop_cnt, sent[nx]);
      end
      nx++;
      tick();
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL wrap_model i=%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    idle();
  endtask

  task automatic test_reset_mid();
    bus.out_ready = 1;
    tick(); tick();
    bus.out_ready = 0;
    n_cmp++;
    if (mq.size() != 5 || obs_vec() !== exp_vec() || bus.overflow !== 1'b1) begin
      n_bad++; $display("FAIL pre_reset: got %h want %h (model depth %0d)", obs_vec(), exp_vec(), mq.size());
    end
    #2 rst = 1;
    model_reset();
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.overflow !== 1'b0 || bus.drop_cnt !== 8'd0 || bus.stall_req !== 1'b0) begin
      n_bad++; $display("FAIL async_reset: got v=%b ovf=%b cnt=%0d stall=%b want all 0",
                        bus.out_valid, bus.overflow, bus.drop_cnt, bus.stall_req);
    end
    @(negedge clk);
    rst = 0;
    bus.out_ready = 1;
    tick(); tick();
    n_cmp++;
    if (obs_vec() !== 81'b0) begin
      n_bad++; $display("FAIL post_reset_stale: got %h want %h", obs_vec(), 81'b0);
    end
  endtask

  task automatic test_filter();
    trec_t a = '{32'hbfc00384, 5'd4, $urandom, 1'b0};
    trec_t b = '{32'hbfc00400, 5'd6, $urandom, 1'b1};
    bus.out_ready = 1;
    drive(0, a); drive(1, b);
    tick();
    idle();
`ifdef TRACE_FILTER_EN
    n_cmp++;
    if (head() !== b || bus.out_valid !== 1'b1) begin
      n_bad++; $display("FAIL filter_pass: got v=%b %h want %h", bus.out_valid, head(), b);
    end
`else
    n_cmp++;
    if (head() !== a || bus.out_valid !== 1'b1) begin
      n_bad++; $display("FAIL nofilter_slot0: got v=%b %h want %h", bus.out_valid, head(), a);
    end
    tick();
    n_cmp++;
    if (head() !== b || bus.out_valid !== 1'b1) begin
      n_bad++; $display("FAIL nofilter_slot1: got v=%b %h want %h", bus.out_valid, head(), b);
    end
`endif
    tick();
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL filter_empty: got v=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      bus.trace_enable = ($urandom % 8) != 0;
      bus.out_ready    = ($urandom % 3) != 0;
      bus.wb0_en    = $urandom; bus.wb1_en = $urandom;
      bus.wb0_rd    = ($urandom % 4 == 0) ? 5'd0 : 5'($urandom);
      bus.wb1_rd    = ($urandom % 4 == 0) ? 5'd0 : 5'($urandom);
      bus.wb0_wdata = $urandom; bus.wb1_wdata = $urandom;
      bus.wb0_pc    = ($urandom % 6 == 0) ? FILTER_PC + 32'($urandom % 8) : {$urandom} & 32'hffff_fffc;
      bus.wb1_pc    = ($urandom % 6 == 0) ? FILTER_PC + 32'($urandom % 8) : {$urandom} & 32'hffff_fffc;
      tick();
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_bad++; $display("FAIL random i=%0d: got %h want %h", i, obs_vec(), exp_vec());
      end
    end
    idle();
    bus.trace_enable = 1;
  endtask

  task automatic test_saturate();
    bus.out_ready = 0;
    for (int i = 0; i < 140; i++) begin
      drive(0, mkrec(300 + 2 * i, 1'b0));
      drive(1, mkrec(301 + 2 * i, 1'b1));
      tick();
    end
    idle();
    n_cmp++;
    if (bus.drop_cnt !== 8'd255 || obs_vec() !== exp_vec()) begin
      n_bad++; $display("FAIL drop_saturate: got cnt=%0d %h want cnt=255 %h", bus.drop_cnt, obs_vec(), exp_vec());
    end
    bus.trace_enable = 0;
    bus.out_ready    = 1;
    drive(0, mkrec(999, 1'b0));
    for (int i = 0; i < 8; i++) tick();
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.drop_cnt !== 8'd255) begin
      n_bad++; $display("FAIL drain_disabled: got v=%b cnt=%0d want v=0 cnt=255", bus.out_valid, bus.drop_cnt);
    end
    idle();
    bus.trace_enable = 1;
  endtask

  initial begin
    idle();
    bus.trace_enable = 1;
    bus.out_ready    = 1;
    test_reset();
    test_dual();
    test_single_slot();
    test_overflow();
    test_wrap();
    test_reset_mid();
    test_filter();
    test_random();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
